// File: rtl/shifter_ctrl_pkg.sv
// Shared types and default sizes for the shifter sequencing controller.
package shifter_ctrl_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned AMT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/shift_step_counter.sv
// Loadable down-counter; last_c flags the final shift step (count == 1).
module shift_step_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shifterMain.sv
// 8-bit load/shift-right register datapath driven by shifter_ctrl.
// The ASR fill bit is taken from loadVal's MSB, so loadVal must be held while shifting.
module shifterMain #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_n,
    input  logic             shift,
    input  logic             asr,
    input  logic [WIDTH-1:0] loadVal,
    output logic [WIDTH-1:0] OutShifter
);

    logic [WIDTH-1:0] out_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_q <= '0;
        end else if (!load_n) begin
            out_q <= loadVal;
        end else if (shift) begin
            out_q <= {asr & loadVal[WIDTH-1], out_q[WIDTH-1:1]};
        end
    end

    assign OutShifter = out_q;

endmodule

// File: rtl/shifter_ctrl.sv
// Sequences one load + N shift steps on shifterMain per command and returns
// the shifter output over a valid/ready response channel.
module shifter_ctrl
    import shifter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned AMT_W = AMT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [AMT_W-1:0] req_amt,
    input  logic             req_asr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] sh_load_val,
    output logic             sh_load_n,
    output logic             sh_shift,
    output logic             sh_asr,
    output logic             sh_reset_n,
    input  logic [WIDTH-1:0] sh_out
);

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             asr_q, asr_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             load_n_q, load_n_d;
    logic             shift_q, shift_d;
    logic             sh_reset_n_q;

    logic [AMT_W-1:0] amt_eff;
    logic [AMT_W-1:0] cnt;
    logic             cnt_last;
    logic             cnt_load;
    logic             cnt_dec;

    // Amounts beyond the datapath width saturate: the result is all fill bits.
    always_comb begin
        amt_eff = (req_amt > AMT_MAX) ? AMT_MAX : req_amt;
    end

    shift_step_counter #(
        .CNT_W (AMT_W)
    ) u_step_cnt (
        .clock      (clock),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (amt_eff),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt),
        .last_c     (cnt_last)
    );

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        asr_d    = asr_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    data_d   = req_data;
                    asr_d    = req_asr;
                    cnt_load = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                state_d = (cnt == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                cnt_dec = 1'b1;
                if (cnt_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they align with state_q.
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == DONE);
        load_n_d    = (state_d != LOAD);
        shift_d     = (state_d == SHIFT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            data_q       <= '0;
            asr_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            load_n_q     <= 1'b1;
            shift_q      <= 1'b0;
            sh_reset_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            asr_q        <= asr_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            load_n_q     <= load_n_d;
            shift_q      <= shift_d;
            sh_reset_n_q <= 1'b1;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = sh_out;
    assign sh_load_val = data_q;
    assign sh_load_n   = load_n_q;
    assign sh_shift    = shift_q;
    assign sh_asr      = asr_q;
    assign sh_reset_n  = sh_reset_n_q;

endmodule

// File: tb/tb_shifter_ctrl.sv
// Directed and random-stream bench for shifter_ctrl driving a shifterMain datapath.
module tb_shifter_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned AMT_W = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [WIDTH-1:0] req_data = '0;
    logic [AMT_W-1:0] req_amt = '0;
    logic             req_asr = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_data;
    logic [WIDTH-1:0] sh_load_val;
    logic             sh_load_n;
    logic             sh_shift;
    logic             sh_asr;
    logic             sh_reset_n;
    logic [WIDTH-1:0] sh_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    shifter_ctrl #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .req_amt     (req_amt),
        .req_asr     (req_asr),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .sh_load_val (sh_load_val),
        .sh_load_n   (sh_load_n),
        .sh_shift    (sh_shift),
        .sh_asr      (sh_asr),
        .sh_reset_n  (sh_reset_n),
        .sh_out      (sh_out)
    );

    shifterMain #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clock      (clock),
        .reset_n    (sh_reset_n),
        .load_n     (sh_load_n),
        .shift      (sh_shift),
        .asr        (sh_asr),
        .loadVal    (sh_load_val),
        .OutShifter (sh_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [3:0] amt, input logic asr);
        int unsigned      eff;
        logic signed [7:0] s;
        eff = (amt > 4'd8) ? 8 : int'(amt);
        s   = d;
        return asr ? 8'(s >>> eff) : 8'(d >> eff);
    endfunction

    // Present one command; returns at the first negedge after the accept edge.
    task automatic send(input logic [7:0] d, input logic [3:0] a, input logic s);
        int k = 0;
        while (!req_ready && k < 40) begin
            @(negedge clock);
            k++;
        end
        check("send_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_data  = d;
        req_amt   = a;
        req_asr   = s;
        @(negedge clock);
        req_valid = 1'b0;
        req_data  = 8'($urandom);
        req_amt   = 4'($urandom);
        req_asr   = 1'($urandom);
    endtask

    task automatic wait_rsp(input string tag, input logic [7:0] exp, input int lat);
        int k = 1;
        while (!rsp_valid && k < 40) begin
            @(negedge clock);
            k++;
        end
        check({tag, "_lat"}, 32'(k), 32'(lat));
        check({tag, "_data"}, 32'(rsp_data), 32'(exp));
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        check("ack_idle", 32'(req_ready), 32'd1);
        check("ack_valid_low", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] q_exp[$];
        int         acc;
        int         got;
        int         cyc;
        int         spurious;

        // Power-on reset values
        repeat (3) @(negedge clock);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_load_n", 32'(sh_load_n), 32'd1);
        check("rst_shift", 32'(sh_shift), 32'd0);
        check("rst_asr", 32'(sh_asr), 32'd0);
        check("rst_load_val", 32'(sh_load_val), 32'd0);
        check("rst_sh_reset_n", 32'(sh_reset_n), 32'd0);
        check("rst_sh_out", 32'(sh_out), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("rel_sh_reset_n", 32'(sh_reset_n), 32'd1);

        // Directed commands with hand-computed results and latencies
        send(8'b1011_0110, 4'd3, 1'b0);
        wait_rsp("lsr3", 8'b0001_0110, 5);
        ack();
        send(8'b1000_0001, 4'd2, 1'b1);
        wait_rsp("asr2", 8'b1110_0000, 4);
        ack();
        send(8'hA5, 4'd0, 1'b0);
        wait_rsp("amt0", 8'hA5, 2);
        ack();
        send(8'hFF, 4'd15, 1'b0);
        wait_rsp("lsr15", 8'h00, 10);
        ack();
        send(8'h80, 4'd15, 1'b1);
        wait_rsp("asr15", 8'hFF, 10);
        ack();

        // Response back-pressure while a second request waits
        send(8'h6D, 4'd2, 1'b0);
        wait_rsp("bp", 8'h1B, 4);
        req_valid = 1'b1;
        req_data  = 8'h3C;
        req_amt   = 4'd1;
        req_asr   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("bp_data", 32'(rsp_data), 32'h1B);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_shift", 32'(sh_shift), 32'd0);
            check("bp_valid", 32'(rsp_valid), 32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        check("bp_idle_ready", 32'(req_ready), 32'd1);
        check("bp_idle_valid", 32'(rsp_valid), 32'd0);
        @(negedge clock);
        req_valid = 1'b0;
        wait_rsp("bp_next", 8'h1E, 3);
        ack();

        // rsp_ready already high when DONE is reached
        rsp_ready = 1'b1;
        send(8'h5A, 4'd1, 1'b1);
        wait_rsp("early", 8'h2D, 3);
        @(negedge clock);
        check("early_valid_low", 32'(rsp_valid), 32'd0);
        check("early_idle", 32'(req_ready), 32'd1);
        rsp_ready = 1'b0;

        // Reset in the middle of SHIFT
        send(8'hC3, 4'd8, 1'b1);
        @(negedge clock);
        check("mid_in_shift", 32'(sh_shift), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_req_ready", 32'(req_ready), 32'd1);
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_load_n", 32'(sh_load_n), 32'd1);
        check("mid_shift", 32'(sh_shift), 32'd0);
        check("mid_asr", 32'(sh_asr), 32'd0);
        check("mid_load_val", 32'(sh_load_val), 32'd0);
        check("mid_sh_reset_n", 32'(sh_reset_n), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        check("mid_sh_out", 32'(sh_out), 32'd0);
        check("mid_rel_sh_reset_n", 32'(sh_reset_n), 32'd0);
        @(negedge clock);
        check("mid_rel2_sh_reset_n", 32'(sh_reset_n), 32'd1);
        check("mid_rel2_ready", 32'(req_ready), 32'd1);
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (rsp_valid) spurious++;
        end
        check("mid_no_rsp", 32'(spurious), 32'd0);

        // Random stream against the reference model
        acc = 0;
        got = 0;
        cyc = 0;
        while ((acc < 200 || got < acc) && cyc < 20000) begin
            @(negedge clock);
            cyc++;
            req_valid = (acc < 200) ? ($urandom_range(0, 3) != 0) : 1'b0;
            req_data  = 8'($urandom);
            req_amt   = 4'($urandom_range(0, 15));
            req_asr   = 1'($urandom);
            rsp_ready = ($urandom_range(0, 2) != 0);
            if (req_valid && req_ready) begin
                q_exp.push_back(ref_shift(req_data, req_amt, req_asr));
                acc++;
            end
            if (rsp_valid && rsp_ready) begin
                check("rnd_pending", 32'(q_exp.size() != 0), 32'd1);
                if (q_exp.size() != 0) begin
                    check("rnd_data", 32'(rsp_data), 32'(q_exp.pop_front()));
                end
                got++;
            end
        end
        @(negedge clock);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("rnd_count", 32'(got), 32'd200);
        check("rnd_queue_empty", 32'(q_exp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shifter_ctrl.md
# shifter_ctrl

Sequencing controller for the 8-bit load/shift register datapath (`shifterMain`). It accepts one shift command at a time over a valid/ready handshake and drives the datapath controls `load_n`, `shift`, `asr` and `reset_n` cycle by cycle. It then returns the datapath output as a response over a second valid/ready handshake. It sits between a command source (FSM, CPU port or switch debouncer) and the shifter, replacing manual KEY sequencing.

## Interface
Parameters:
- `WIDTH`, 8: datapath width; must match the shifter.
- `AMT_W`, 4: shift-amount field width; must satisfy 2^`AMT_W` > `WIDTH`.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: command present.
- `req_ready` out 1: controller can accept a command.
- `req_data` in `WIDTH`: value to load.
- `req_amt` in `AMT_W`: number of shift steps.
- `req_asr` in 1: 1 = arithmetic (sign-fill), 0 = logical (zero-fill).
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer takes the result.
- `rsp_data` out `WIDTH`: shifted result.
- `sh_load_val` out `WIDTH`: drives shifter `loadVal`.
- `sh_load_n` out 1: drives shifter `load_n`; active-low.
- `sh_shift` out 1: drives shifter `shift`.
- `sh_asr` out 1: drives shifter `asr`.
- `sh_reset_n` out 1: drives shifter synchronous `reset_n`.
- `sh_out` in `WIDTH`: shifter `OutShifter`.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, capture `req_data`, `req_asr` and the effective amount into registers, then go to LOAD.
  - Effective amount = min(`req_amt`, `WIDTH`).
- **LOAD** (exactly 1 cycle)
  - `sh_load_n`=0, `sh_shift`=0.
  - Next state is SHIFT if amount > 0, else DONE.
- **SHIFT**
  - `sh_load_n`=1, `sh_shift`=1, down-counter decrements each cycle.
  - Go to DONE in the cycle the counter reaches 1, giving exactly `amount` shift cycles.
- **DONE**
  - `sh_load_n`=1, `sh_shift`=0, so the shifter holds its value.
  - `rsp_valid`=1; `rsp_data` = `sh_out`, stable while waiting.
  - On `rsp_ready`, go to IDLE.
- Captured value and flag:
  - `sh_load_val` = captured value from LOAD through DONE. The shifter's ASR fill bit is `loadVal[MSB]`, so this value must stay constant while shifting.
  - `sh_asr` = captured flag.
- `req_ready` is 0 outside IDLE. There is no back-to-back acceptance; a minimum of 1 IDLE cycle separates commands.
- Command fields are ignored unless the `req_valid`&`req_ready` handshake occurs.
- `rsp_valid` is asserted only in DONE. No result is dropped or duplicated.
- `req_amt` values above `WIDTH` clamp to `WIDTH`:
  - logical shift → result 0;
  - arithmetic shift → all bits = sign bit.

## Timing
- Reset values:
  - state IDLE;
  - `req_ready`=1, `rsp_valid`=0;
  - `sh_load_n`=1, `sh_shift`=0, `sh_asr`=0;
  - `sh_load_val`=0, `sh_reset_n`=0, counter 0.
- `sh_reset_n` is registered. It is 0 during reset and goes 1 on the first rising edge after reset deasserts. The shifter therefore clears on every edge while `reset` is high.
- Latency: accept edge E.
  - `rsp_valid` rises after edge E+1+amount, i.e. amount+2 cycles after acceptance.
  - amount 0 → 2 cycles.
- All `sh_*` outputs are registered or decoded from the registered state only. There is no combinational path from `req_*` or `rsp_ready` to `sh_*`.
- Reset mid-operation (any state): immediately return to IDLE with reset values. No `rsp_valid` is issued for the aborted command.
- `rsp_ready` held high ahead of DONE: the handshake completes in the first DONE cycle and the state is IDLE the next cycle.

## Structure
- Package `shifter_ctrl_pkg`:
  - state enum (IDLE, LOAD, SHIFT, DONE);
  - default `WIDTH`/`AMT_W` constants.
- One sub-module, `shift_step_counter`: loadable down-counter with a "last" flag.
- FSM and capture registers stay in `shifter_ctrl`.
- Bench instantiates `shifter_ctrl` plus `shifterMain` with `sh_*` connected.

## Test plan
- Reset: assert `reset` mid-SHIFT → outputs take reset values immediately; after release `req_ready`=1, `sh_reset_n` goes 1 one edge later.
- Logical: data 8'b1011_0110, amt 3, asr 0 → `rsp_data`=8'b0001_0110, `rsp_valid` 5 cycles after accept.
- Arithmetic: data 8'b1000_0001, amt 2, asr 1 → `rsp_data`=8'b1110_0000.
- Boundaries:
  - amt 0, data 8'hA5 → `rsp_data`=8'hA5 after 2 cycles;
  - amt 15, asr 0, data 8'hFF → 8'h00;
  - amt 15, asr 1, data 8'h80 → 8'hFF.
- Back-pressure: `rsp_ready` low 10 cycles in DONE → `rsp_data` stable, `req_ready`=0, `sh_shift`=0 throughout; `req_valid` held high meanwhile is not accepted until IDLE.
- Random stream: 200 commands with random `req_valid`/`rsp_ready` → results match the reference model in order, none lost or duplicated.
